// File: rtl/risc_toy_fetch_queue.sv
// RISC_TOY instruction-fetch front end: PC ownership, 1-cycle memory request pipe and a DEPTH-entry fetch FIFO.
// Optional in-fetch J prediction is enabled by defining RISC_TOY_FETCH_JPRED_EN.
module risc_toy_fetch_queue #(
  parameter int             AW       = 30,
  parameter int             DW       = 32,
  parameter int             DEPTH    = 4,
  parameter logic [AW-1:0]  RESET_PC = '0,
  localparam int            PW       = $clog2(DEPTH),
  localparam int            CW       = PW + 1
) (
  input  logic          CLK,
  input  logic          RSTN,
  output logic          IREQ,
  output logic [AW-1:0] IADDR,
  input  logic [DW-1:0] INSTR,
  input  logic          REDIR_V,
  input  logic [AW-1:0] REDIR_PC,
  output logic          O_VALID,
  input  logic          O_READY,
  output logic [DW-1:0] O_INSTR,
  output logic [AW-1:0] O_PC,
  output logic [CW-1:0] FQ_CNT
);

  logic [AW-1:0] fetch_pc_q, fetch_pc_d;
  logic          inflight_q, inflight_d;
  logic [AW-1:0] inflight_pc_q, inflight_pc_d;
  logic          inflight_epoch_q, inflight_epoch_d;
  logic          epoch_q, epoch_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [DW-1:0] entry_instr [DEPTH];
  logic [AW-1:0] entry_pc    [DEPTH];

  logic          pop;
  logic          resp;
  logic          push;
  logic          issue;
  logic          jpred;
  logic [CW:0]   occ;

  assign O_VALID = (cnt_q != '0);
  assign pop     = O_VALID & O_READY;
  // Occupancy the FIFO will need to absorb if nothing new were issued.
  assign occ     = {1'b0, cnt_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
  assign issue   = RSTN & ~REDIR_V & (occ < (CW+1)'(DEPTH));
  assign resp    = inflight_q & (inflight_epoch_q == epoch_q);
  assign push    = resp & ~REDIR_V;

`ifdef RISC_TOY_FETCH_JPRED_EN
  logic [AW-1:0] jump_pc;
  assign jpred   = push & (INSTR[31:27] == 5'b10001);
  assign jump_pc = inflight_pc_q + {{(AW-20){INSTR[21]}}, INSTR[21:2]};
`else
  assign jpred   = 1'b0;
`endif

  assign IREQ    = issue;
  assign IADDR   = fetch_pc_q;
  assign FQ_CNT  = cnt_q;
  assign O_INSTR = entry_instr[rd_ptr_q];
  assign O_PC    = entry_pc[rd_ptr_q];

  always_comb begin
    fetch_pc_d       = fetch_pc_q;
    epoch_d          = epoch_q ^ (REDIR_V | jpred);
    inflight_d       = issue;
    inflight_pc_d    = fetch_pc_q;
    inflight_epoch_d = epoch_q;
    if (issue) begin
      fetch_pc_d = fetch_pc_q + AW'(1);
    end
`ifdef RISC_TOY_FETCH_JPRED_EN
    if (jpred) begin
      fetch_pc_d = jump_pc;
    end
`endif
    if (REDIR_V) begin
      fetch_pc_d = REDIR_PC;
    end
  end

  // A redirect still lets the current pop complete; it only empties what is left.
  always_comb begin
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(push);
    if (REDIR_V) begin
      cnt_d    = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      fetch_pc_q       <= RESET_PC;
      inflight_q       <= 1'b0;
      inflight_pc_q    <= RESET_PC;
      inflight_epoch_q <= 1'b0;
      epoch_q          <= 1'b0;
      rd_ptr_q         <= '0;
      wr_ptr_q         <= '0;
      cnt_q            <= '0;
    end else begin
      fetch_pc_q       <= fetch_pc_d;
      inflight_q       <= inflight_d;
      inflight_pc_q    <= inflight_pc_d;
      inflight_epoch_q <= inflight_epoch_d;
      epoch_q          <= epoch_d;
      rd_ptr_q         <= rd_ptr_d;
      wr_ptr_q         <= wr_ptr_d;
      cnt_q            <= cnt_d;
    end
  end

  // Storage entries carry no reset; their contents are only observed while counted.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [DW-1:0] instr_q, instr_d;
    logic [AW-1:0] pc_q, pc_d;

    always_comb begin
      instr_d = instr_q;
      pc_d    = pc_q;
      if (push && (wr_ptr_q == PW'(gi))) begin
        instr_d = INSTR;
        pc_d    = inflight_pc_q;
      end
    end

    always_ff @(posedge CLK) begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end

    assign entry_instr[gi] = instr_q;
    assign entry_pc[gi]    = pc_q;
  end

endmodule

// File: tb/tb_risc_toy_fetch_queue.sv
// Bench for risc_toy_fetch_queue: queue-level reference model compared every cycle plus directed literal checks.
`timescale 1ns/1ps
module tb_risc_toy_fetch_queue;
  localparam int             AW     = 30;
  localparam int             DW     = 32;
  localparam int             DEPTH  = 4;
  localparam int             CW     = 3;
  localparam logic [AW-1:0]  RST_PC = 30'h10;
  // J at 0x20 with word offset -4 in bits [21:2]
  localparam logic [DW-1:0]  J_WORD = 32'h883F_FFF0;

  logic          CLK = 1'b0;
  logic          RSTN = 1'b0;
  logic          IREQ;
  logic [AW-1:0] IADDR;
  logic [DW-1:0] INSTR = '0;
  logic          REDIR_V = 1'b0;
  logic [AW-1:0] REDIR_PC = '0;
  logic          O_VALID;
  logic          O_READY = 1'b1;
  logic [DW-1:0] O_INSTR;
  logic [AW-1:0] O_PC;
  logic [CW-1:0] FQ_CNT;

  risc_toy_fetch_queue #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .CLK(CLK), .RSTN(RSTN), .IREQ(IREQ), .IADDR(IADDR), .INSTR(INSTR),
    .REDIR_V(REDIR_V), .REDIR_PC(REDIR_PC), .O_VALID(O_VALID), .O_READY(O_READY),
    .O_INSTR(O_INSTR), .O_PC(O_PC), .FQ_CNT(FQ_CNT)
  );

  always #5 CLK = ~CLK;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return (a == 30'h20) ? J_WORD : {2'b00, a};
  endfunction

  always @(posedge CLK) INSTR <= mem_word(IADDR);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a plain queue of accepted fetches plus one outstanding request.
  typedef struct packed {
    logic [DW-1:0] instr;
    logic [AW-1:0] pc;
  } entry_t;

  entry_t        fq[$];
  logic [AW-1:0] acc_log[$];
  logic [AW-1:0] m_pc = RST_PC;
  logic [AW-1:0] m_infl_pc = '0;
  bit            m_infl = 0;
  bit            m_live = 0;
  bit            m_known = 0;

  function automatic logic [AW-1:0] log_at(input int i);
    return (i < acc_log.size()) ? acc_log[i] : '1;
  endfunction

  always @(negedge CLK) begin
    bit            pop;
    bit            exp_ireq;
    bit            resp;
    int            occ;
    entry_t        e;
    entry_t        ne;
    logic [AW-1:0] jpc;
    pop      = (fq.size() != 0) && O_READY;
    occ      = fq.size() + int'(m_infl) - int'(pop);
    exp_ireq = RSTN && !REDIR_V && (occ < DEPTH);
    if (m_known) begin
      chk("ireq", IREQ, exp_ireq);
      chk("iaddr", IADDR, m_pc);
      chk("o_valid", O_VALID, fq.size() != 0);
      chk("fq_cnt", FQ_CNT, fq.size());
      if (fq.size() != 0) begin
        chk("o_pc", O_PC, fq[0].pc);
        chk("o_instr", O_INSTR, fq[0].instr);
      end
    end
    if (!RSTN) begin
      fq.delete();
      m_pc    = RST_PC;
      m_infl  = 0;
      m_live  = 0;
      m_known = 1;
    end else if (m_known) begin
      resp = m_infl && m_live;
      jpc  = m_infl_pc;
      if (pop) begin
        e = fq.pop_front();
        acc_log.push_back(e.pc);
        $display("[TB] accept pc=0x%0h instr=0x%0h", e.pc, e.instr);
      end
      if (REDIR_V) begin
        fq.delete();
        m_pc   = REDIR_PC;
        m_infl = 0;
        m_live = 0;
      end else begin
        if (resp) begin
          ne.instr = INSTR;
          ne.pc    = jpc;
          fq.push_back(ne);
        end
        if (exp_ireq) begin
          m_infl    = 1;
          m_live    = 1;
          m_infl_pc = m_pc;
          m_pc      = m_pc + 1'b1;
        end else begin
          m_infl = 0;
        end
`ifdef RISC_TOY_FETCH_JPRED_EN
        if (resp && INSTR[31:27] == 5'b10001) begin
          m_pc   = AW'(longint'(jpc) + longint'($signed(INSTR[21:2])));
          m_live = 0;
        end
`endif
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset(input bit ready);
    RSTN    = 1'b0;
    REDIR_V = 1'b0;
    O_READY = ready;
    repeat (3) tick();
    acc_log.delete();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int hits;
    logic [23:0] pat;

    // Reset and free-running stream from RESET_PC
    do_reset(1'b1);
    chk("rst_ireq", IREQ, 0);
    chk("rst_valid", O_VALID, 0);
    chk("rst_cnt", FQ_CNT, 0);
    chk("rst_iaddr", IADDR, 30'h10);
    RSTN = 1'b1;
    #1;
    chk("t1_c0_ireq", IREQ, 1);
    chk("t1_c0_iaddr", IADDR, 30'h10);
    tick();
    chk("t1_c1_iaddr", IADDR, 30'h11);
    chk("t1_c1_valid", O_VALID, 0);
    tick();
    chk("t1_c2_valid", O_VALID, 1);
    chk("t1_c2_pc", O_PC, 30'h10);
    chk("t1_c2_instr", O_INSTR, 32'h10);
    repeat (5) tick();
    chk("t1_log_n", acc_log.size(), 5);
    for (int i = 0; i < 5; i++) chk("t1_log", log_at(i), 30'h10 + i);

    // Back-pressure fills the FIFO to DEPTH
    do_reset(1'b0);
    RSTN = 1'b1;
    repeat (3) tick();
    chk("t2_c3_ireq", IREQ, 1);
    tick();
    chk("t2_c4_ireq", IREQ, 0);
    chk("t2_c4_cnt", FQ_CNT, 3);
    repeat (2) tick();
    chk("t2_c6_cnt", FQ_CNT, 4);
    chk("t2_c6_ireq", IREQ, 0);
    chk("t2_c6_pc", O_PC, 30'h10);
    O_READY = 1'b1;

    // Redirect coincident with the pop of head 0x14
    for (int i = 0; i < 20 && !(O_VALID === 1'b1 && O_PC === 30'h14); i++) tick();
    chk("t5_head_found", (O_VALID === 1'b1 && O_PC === 30'h14), 1);
    chk("t2_log_n", acc_log.size(), 4);
    for (int i = 0; i < 4; i++) chk("t2_log", log_at(i), 30'h10 + i);
    REDIR_V  = 1'b1;
    REDIR_PC = 30'h40;
    #1;
    chk("t5_redir_ireq", IREQ, 0);
    tick();
    REDIR_V = 1'b0;
    #1;
    chk("t5_empty_valid", O_VALID, 0);
    chk("t5_empty_cnt", FQ_CNT, 0);
    chk("t5_iaddr", IADDR, 30'h40);
    repeat (6) tick();
    hits = 0;
    foreach (acc_log[i]) if (acc_log[i] == 30'h14) hits++;
    chk("t5_once", hits, 1);
    chk("t5_log_head", log_at(4), 30'h14);
    chk("t5_log_next", log_at(5), 30'h40);

    // Redirect in a steady stream
    repeat (2) tick();
    REDIR_V  = 1'b1;
    REDIR_PC = 30'h200;
    #1;
    chk("t3_redir_ireq", IREQ, 0);
    tick();
    REDIR_V = 1'b0;
    #1;
    n0 = acc_log.size();
    chk("t3_r1_valid", O_VALID, 0);
    chk("t3_r1_iaddr", IADDR, 30'h200);
    chk("t3_r1_ireq", IREQ, 1);
    tick();
    chk("t3_r2_valid", O_VALID, 0);
    tick();
    chk("t3_r3_valid", O_VALID, 1);
    chk("t3_r3_pc", O_PC, 30'h200);
    chk("t3_r3_instr", O_INSTR, 32'h200);
    repeat (3) tick();
    chk("t3_log0", log_at(n0), 30'h200);
    chk("t3_log1", log_at(n0 + 1), 30'h201);

    // Address wrap at the top of the word space
    REDIR_V  = 1'b1;
    REDIR_PC = 30'h3FFF_FFFE;
    tick();
    REDIR_V = 1'b0;
    #1;
    n0 = acc_log.size();
    chk("t4_iaddr0", IADDR, 30'h3FFF_FFFE);
    tick();
    chk("t4_iaddr1", IADDR, 30'h3FFF_FFFF);
    tick();
    chk("t4_iaddr2", IADDR, 30'h0);
    repeat (5) tick();
    chk("t4_log0", log_at(n0), 30'h3FFF_FFFE);
    chk("t4_log1", log_at(n0 + 1), 30'h3FFF_FFFF);
    chk("t4_log2", log_at(n0 + 2), 30'h0);
    chk("t4_log3", log_at(n0 + 3), 30'h1);

    // Irregular ready pattern after a redirect
    REDIR_V  = 1'b1;
    REDIR_PC = 30'h100;
    tick();
    REDIR_V = 1'b0;
    pat = 24'b1011_0010_0111_0001_1100_1010;
    for (int i = 0; i < 24; i++) begin
      O_READY = pat[i];
      tick();
    end
    O_READY = 1'b1;

    // Reset in the middle of a stream
    RSTN = 1'b0;
    tick();
    chk("mr_valid", O_VALID, 0);
    chk("mr_cnt", FQ_CNT, 0);
    chk("mr_ireq", IREQ, 0);
    chk("mr_iaddr", IADDR, 30'h10);
    tick();
    RSTN = 1'b1;
    repeat (4) tick();

    // J word at 0x20
    REDIR_V  = 1'b1;
    REDIR_PC = 30'h1E;
    tick();
    REDIR_V = 1'b0;
    n0 = acc_log.size();
    repeat (10) tick();
    chk("t6_log0", log_at(n0), 30'h1E);
    chk("t6_log1", log_at(n0 + 1), 30'h1F);
    chk("t6_log2", log_at(n0 + 2), 30'h20);
`ifdef RISC_TOY_FETCH_JPRED_EN
    chk("t6_log3", log_at(n0 + 3), 30'h1C);
    hits = 0;
    for (int i = n0; i < acc_log.size(); i++) if (acc_log[i] == 30'h21) hits++;
    chk("t6_no_0x21", hits, 0);
`else
    chk("t6_log3", log_at(n0 + 3), 30'h21);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
